// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: size codes, FSM states, default address width
// and lane-normalisation helpers used by the top and the load aligner.
package load_store_unit_pkg;

    localparam int unsigned LSU_ADDR_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Half needs addr[0]==0, word (and reserved, treated as word) needs addr[1:0]==0.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return (lo != 2'b00);
        endcase
    endfunction

    // Drops the low address bits an access of this size cannot use.
    function automatic logic [1:0] eff_lane(input size_e size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data aligner: picks the addressed byte/half lane from the returned word and
// sign- or zero-extends it to 32 bits; words pass through untouched.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time over a req/gnt/rvalid memory port, with
// register-file write-back for loads. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign_err,
    output logic              busy
);

    state_e            state_q,        state_d;
    size_e             size_q,         size_d;
    logic              unsigned_q,     unsigned_d;
    logic [1:0]        lane_q,         lane_d;
    logic [4:0]        rd_q,           rd_d;
    logic              mem_req_q,      mem_req_d;
    logic              mem_we_q,       mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
    logic [3:0]        mem_be_q,       mem_be_d;
    logic [31:0]       mem_wdata_q,    mem_wdata_d;
    logic              wb_we_q,        wb_we_d;
    logic [4:0]        wb_rd_q,        wb_rd_d;
    logic [31:0]       wb_data_q,      wb_data_d;
    logic              misalign_err_q, misalign_err_d;

    size_e       in_size;
    logic [1:0]  in_lane;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] load_result;

    lsu_load_align u_load_align (
        .rdata       (mem_rdata),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (load_result)
    );

    // Store lane encoding on the incoming request.
    always_comb begin
        in_size = size_e'(req_size);
        in_lane = eff_lane(in_size, req_addr[1:0]);
        case (in_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << in_lane;
                st_wdata = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be    = in_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d        = state_q;
        size_d         = size_q;
        unsigned_d     = unsigned_q;
        lane_d         = lane_q;
        rd_d           = rd_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        wb_we_d        = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        misalign_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d      = in_size;
                    unsigned_d  = req_unsigned;
                    lane_d      = in_lane;
                    rd_d        = req_rd;
                    mem_we_d    = req_we;
                    mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = req_we ? st_be : 4'b1111;
                    mem_wdata_d = st_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(in_size, req_addr[1:0])) begin
                        state_d        = ST_ERR;
                        misalign_err_d = 1'b1;
                    end else begin
                        state_d   = ST_REQ;
                        mem_req_d = 1'b1;
                    end
`else
                    state_d   = ST_REQ;
                    mem_req_d = 1'b1;
`endif
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_we_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    wb_data_d = load_result;
                    wb_rd_d   = rd_q;
                    wb_we_d   = (rd_q != 5'd0);
                    state_d   = ST_IDLE;
                end
            end
`ifdef LSU_MISALIGN_TRAP_EN
            ST_ERR: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous, and all state updates use non-blocking assignment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            size_q         <= SZ_BYTE;
            unsigned_q     <= 1'b0;
            lane_q         <= 2'b00;
            rd_q           <= 5'd0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= 4'b0000;
            mem_wdata_q    <= 32'h0;
            wb_we_q        <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'h0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            size_q         <= size_d;
            unsigned_q     <= unsigned_d;
            lane_q         <= lane_d;
            rd_q           <= rd_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            wb_we_q        <= wb_we_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between execute and the register array.
- Accepts one load/store request at a time from execute and drives a single-port data-memory request/grant/response interface.
- For loads: extracts, aligns and sign/zero-extends the returned data. Produces the register-file write port signals: destination index, write data, write enable.

Parameters:
ADDR_W, 32, byte-address width; data width fixed at 32.

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  execute presents a request
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low bits used for byte/half)
req_rd  in  5  load destination register
mem_req  out  1  memory request, held until granted
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data word
wb_we  out  1  register write enable, one-cycle pulse
wb_rd  out  5  register index
wb_data  out  32  extended load result
misalign_err  out  1  one-cycle misaligned-access pulse
busy  out  1  state != IDLE

Behaviour:
- Reset when rst_n=0 at posedge:
  - State goes to IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_we, wb_rd, wb_data, misalign_err and busy all go to 0.
  - req_ready=1 (combinational from IDLE).
- FSM states: IDLE, REQ, WAIT, ERR.
- IDLE: on req_valid&&req_ready, latch we/size/unsigned/addr/wdata/rd.
  - Aligned request: go to REQ, with mem_* registered so mem_req=1 in the following cycle.
  - Misaligned request (feature enabled): go to ERR.
- REQ: mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_gnt=1 is sampled.
  - On that edge mem_req drops.
  - Store: completes on grant, returns to IDLE, wb_we stays 0.
  - Load: goes to WAIT.
  - mem_rvalid in REQ is ignored.
- WAIT: on mem_rvalid, register the result and return to IDLE.
  - Lane select by addr[1:0]: byte uses lane addr[1:0]; half uses lane addr[1].
  - Extension: sign or zero per req_unsigned; word passes through.
  - wb_data and wb_rd set; wb_we=1 for exactly one cycle.
  - wb_we is suppressed when rd==0.
- Store encoding:
  - Byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Half: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}.
  - Word: be=4'b1111, wdata unchanged.
  - Loads: mem_be=4'b1111.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Minimum load latency (gnt same cycle as mem_req, rvalid next cycle):
  - accept at edge N, mem_req high in N+1, gnt in N+1, rvalid in N+2, wb_we high in N+3.
- Minimum store latency: accept at N, mem_req high in N+1 with gnt, req_ready again in N+2.
- Boundary cases:
  - mem_rvalid while IDLE is ignored.
  - Reset mid-REQ/WAIT: mem_req drops at that edge; any late response is ignored.
  - req_valid while busy is not accepted; requester holds.
  - wb_we and req_ready may be high in the same cycle, allowing back-to-back operation.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request is accepted, but no memory access occurs.
  - ERR state lasts one cycle, with misalign_err=1 and wb_we=0.
  - Then IDLE.
- Undefined:
  - No ERR state; misalign_err tied 0.
  - Offending low address bits are ignored: half uses addr[1] only; word treats addr[1:0] as 00.

Decomposition:
- Shared include lsu_defs.vh holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state encodings
  - default ADDR_W
- One natural combinational sub-module: lsu_load_align (rdata, addr[1:0], size, unsigned → 32-bit result).
- Store-lane logic stays inline.

Test Plan:
- LW addr 0x100, rd=5, rdata=0xDEADBEEF, gnt immediate, rvalid next cycle -> wb_we pulse 3 cycles after accept, wb_rd=5, wb_data=0xDEADBEEF.
- LB signed addr 0x103, rdata=0x80FFFFFF -> wb_data=0xFFFFFF80; same access as LBU -> 0x00000080; LHU addr 0x102, rdata=0xBEEF1234 -> 0x0000BEEF.
- SB addr 0x201, wdata=0x000000AB -> mem_addr=0x200, mem_be=0010, mem_wdata=0xABABABAB, mem_we=1, no wb_we; SH addr 0x202 -> be=1100.
- Load with mem_gnt held low 4 cycles -> mem_req/mem_addr stable for all 4 cycles, req_ready=0 throughout, result correct after grant.
- LW addr 0x101 with LSU_MISALIGN_TRAP_EN -> misalign_err one-cycle pulse, mem_req never asserted, wb_we=0; without macro -> access to 0x100, be=1111.
- rst_n low during WAIT, then late mem_rvalid=1 -> all outputs 0 after reset edge, no wb_we, req_ready=1.
